// File: rtl/dm_access_ctrl.sv
// Load/store sequencer driving the 1024x16 data memory with registered we_DM/addrDM/dataDM.
// Latency accept->resp_valid: store 3+WE_CYCLES, load 2+RD_WAIT, out-of-range 1 cycle.
// Backpressure: req_ready high only in IDLE; req_valid while busy is ignored and must be held.
module dm_access_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int WE_CYCLES = 1,
    parameter int RD_WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        we_DM,
    output logic [15:0] addrDM,
    output logic [15:0] dataDM,
    input  logic [15:0] outDM
);

    localparam int CNT_MAX = (WE_CYCLES > RD_WAIT) ? WE_CYCLES : RD_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WSTROBE,
        WHOLD,
        RWAIT,
        RESP
    } state_t;

    state_t        state;
    logic          op_we;
    logic [CW-1:0] cnt;
    logic          addr_bad;

    // Compare on 17 bits so the full 16-bit address is checked without wrap.
    assign addr_bad = ({1'b0, req_addr} >= MEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            we_DM      <= 1'b0;
            addrDM     <= '0;
            dataDM     <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        op_we     <= req_we;
                        if (addr_bad) begin
                            // Rejected requests never touch the memory pins.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state  <= SETUP;
                            addrDM <= req_addr;
                            if (req_we) begin
                                dataDM <= req_wdata;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (op_we) begin
                        we_DM <= 1'b1;
                        cnt   <= CW'(WE_CYCLES - 1);
                        state <= WSTROBE;
                    end else begin
                        cnt   <= CW'(RD_WAIT - 1);
                        state <= RWAIT;
                    end
                end
                WSTROBE: begin
                    if (cnt == '0) begin
                        we_DM <= 1'b0;
                        state <= WHOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WHOLD: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RWAIT: begin
                    if (cnt == '0) begin
                        resp_rdata <= outDM;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    we_DM     <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: two builds (WE_CYCLES/RD_WAIT = 1/2 and 3/4), each with its own memory.
module tb_dm_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        resp_valid[2];
    logic [15:0] resp_rdata[2];
    logic        resp_err  [2];
    logic        busy      [2];
    logic        we_DM     [2];
    logic [15:0] addrDM    [2];
    logic [15:0] dataDM    [2];
    logic [15:0] outDM     [2];

    dm_access_ctrl #(.MEM_WORDS(1024), .WE_CYCLES(1), .RD_WAIT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0]), .we_DM(we_DM[0]), .addrDM(addrDM[0]), .dataDM(dataDM[0]),
        .outDM(outDM[0])
    );

    dm_access_ctrl #(.MEM_WORDS(1024), .WE_CYCLES(3), .RD_WAIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1]), .we_DM(we_DM[1]), .addrDM(addrDM[1]), .dataDM(dataDM[1]),
        .outDM(outDM[1])
    );

    // Synchronous-write, registered-read data memories.
    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];
    always @(posedge clk) begin
        if (we_DM[0]) mem0[addrDM[0][9:0]] <= dataDM[0];
        outDM[0] <= mem0[addrDM[0][9:0]];
        if (we_DM[1]) mem1[addrDM[1][9:0]] <= dataDM[1];
        outDM[1] <= mem1[addrDM[1][9:0]];
    end

    // Reference model: expected memory contents and which words hold known data.
    logic [15:0] model   [2][1024];
    bit          written [2][1024];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int we_cycles(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int rd_wait(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    // One transaction, entered and left at a negedge. With hold_next the next request is
    // presented (req_valid kept high) right after this one is accepted.
    task automatic do_txn(input int i, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit hold_next, input bit nwe,
                          input logic [15:0] naddr, input logic [15:0] nwdata,
                          output int waited);
        int          lat      = -1;
        int          we_cnt   = 0;
        int          ready_hi = 0;
        int          exp_lat;
        bit          err;
        bit          setup_ok = 1'b0;
        bit          seen_we  = 1'b0;
        logic        prev_we  = 1'b0;
        logic [15:0] prev_a   = 16'hxxxx;
        logic [15:0] prev_d   = 16'hxxxx;
        logic [15:0] addr_before, rdata_before, r_rdata, r_addr;
        logic        r_err;
        err          = (int'(addr) >= 1024);
        addr_before  = addrDM[i];
        rdata_before = resp_rdata[i];
        r_rdata      = 16'hxxxx;
        r_addr       = 16'hxxxx;
        r_err        = 1'bx;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_valid[i] = 1'b1;
        waited = 0;
        while (!req_ready[i] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait_bounded", 32'(waited < 50), 32'd1);
        @(negedge clk);
        if (hold_next) begin
            req_we[i]    = nwe;
            req_addr[i]  = naddr;
            req_wdata[i] = nwdata;
        end else begin
            req_valid[i] = 1'b0;
        end
        for (int k = 1; k <= 20; k++) begin
            if (req_ready[i]) ready_hi++;
            if (we_DM[i]) begin
                we_cnt++;
                if (!seen_we) begin
                    seen_we  = 1'b1;
                    setup_ok = (prev_we == 1'b0) && (prev_a === addr) && (prev_d === wdata);
                end
            end
            if (resp_valid[i]) begin
                lat     = k;
                r_rdata = resp_rdata[i];
                r_err   = resp_err[i];
                r_addr  = addrDM[i];
                break;
            end
            prev_we = we_DM[i];
            prev_a  = addrDM[i];
            prev_d  = dataDM[i];
            @(negedge clk);
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid[i]), 32'd0);
        chk("ready_after_resp", 32'(req_ready[i]), 32'd1);

        exp_lat = err ? 1 : (we ? 3 + we_cycles(i) : 2 + rd_wait(i));
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", 32'(r_err), 32'(err));
        chk("ready_low_while_busy", 32'(ready_hi), 32'd0);
        chk("we_high_cycles", 32'(we_cnt), 32'((!err && we) ? we_cycles(i) : 0));
        if (err) begin
            chk("err_addr_unchanged", 32'(r_addr), 32'(addr_before));
            chk("err_rdata_zero", 32'(r_rdata), 32'd0);
        end else begin
            chk("addrDM", 32'(r_addr), 32'(addr));
            if (we) begin
                chk("setup_before_we", 32'(setup_ok), 32'd1);
                chk("store_rdata_kept", 32'(r_rdata), 32'(rdata_before));
                model[i][addr[9:0]]   = wdata;
                written[i][addr[9:0]] = 1'b1;
            end else begin
                chk("load_rdata", 32'(r_rdata), 32'(model[i][addr[9:0]]));
            end
        end
    endtask

    initial begin
        int          waited;
        bit          we;
        logic [15:0] addr, wdata;
        int          sel;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            for (int a = 0; a < 1024; a++) written[i][a] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_resp_rdata", 32'(resp_rdata[i]), 32'd0);
            chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
            chk("rst_we_DM", 32'(we_DM[i]), 32'd0);
            chk("rst_addrDM", 32'(addrDM[i]), 32'd0);
            chk("rst_dataDM", 32'(dataDM[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a store strobe: data 0 matches unwritten-known content anyway.
        req_we[0] = 1'b1; req_addr[0] = 16'h0300; req_wdata[0] = 16'h0000; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mid_store_we_high", 32'(we_DM[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we_DM", 32'(we_DM[0]), 32'd0);
        chk("async_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready[0]), 32'd1);

        // Directed cases on both builds.
        for (int i = 0; i < 2; i++) begin
            do_txn(i, 1'b1, 16'h0005, 16'h1DFE, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            do_txn(i, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            do_txn(i, 1'b1, 16'd1023, 16'hA001, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            do_txn(i, 1'b0, 16'd1023, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            do_txn(i, 1'b0, 16'd1024, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            do_txn(i, 1'b1, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            do_txn(i, 1'b1, 16'h0010, 16'h1001, 1'b1, 1'b0, 16'h0010, 16'h0000, waited);
            do_txn(i, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, waited);
            chk("held_req_accept_wait", 32'(waited), 32'd0);
        end

        // Randomized traffic; loads only target words with known contents.
        for (int n = 0; n < 120; n++) begin
            int i;
            i     = n % 2;
            we    = 1'($urandom_range(1, 0));
            wdata = 16'($urandom);
            sel   = $urandom_range(7, 0);
            if (sel == 0)      addr = 16'(32'd1024 + $urandom_range(64511, 0));
            else if (sel == 1) addr = 16'hFFFF;
            else if (sel == 2) addr = 16'd1023;
            else               addr = 16'($urandom_range(1023, 0));
            if (!we && int'(addr) < 1024) begin
                while (!written[i][addr[9:0]]) addr = 16'((int'(addr) + 1) % 1024);
            end
            do_txn(i, we, addr, wdata, 1'b0, 1'b0, 16'h0, 16'h0, waited);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
